// File: rtl/stim_seq_pkg.sv
// Shared definitions for the stim_seq stimulus sweeper: FSM state encoding
// and the binary-to-Gray conversion used by the optional Gray-order build.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned MAX_WIDTH = 16;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/stim_dwell_timer.sv
// Dwell counter: counts enabled cycles and asserts tick on the cycle the
// count reaches DWELL-1, wrapping back to zero on that cycle.
module stim_dwell_timer
  import stim_seq_pkg::*;
#(
  parameter int unsigned DWELL = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/stim_seq.sv
// Exhaustive stimulus sweeper: presents all 2^WIDTH patterns, each for DWELL
// non-hold cycles. Define STIM_SEQ_GRAY_EN for Gray-ordered patterns.
module stim_seq
  import stim_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DWELL = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             repeat_en,
  output logic [WIDTH-1:0] pattern,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] LAST_IDX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] pattern_q;
  logic             valid_q, last_q, busy_q, done_q;
  logic             tick, timer_clr, timer_en;

  function automatic logic [WIDTH-1:0] to_pattern(input logic [WIDTH-1:0] b);
`ifdef STIM_SEQ_GRAY_EN
    logic [MAX_WIDTH-1:0] g;
    g = bin2gray(MAX_WIDTH'(b));
    return g[WIDTH-1:0];
`else
    return b;
`endif
  endfunction

  // Timer is held at zero outside RUN and on stop, so every sweep starts fresh.
  assign timer_en  = (state_q == RUN) && !hold && !stop;
  assign timer_clr = (state_q != RUN) || stop;
  assign idx_d     = idx_q + 1'b1;

  stim_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pattern_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q   <= RUN;
            idx_q     <= '0;
            pattern_q <= to_pattern('0);
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            last_q    <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pattern_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
          end else if (tick) begin
            if (idx_q == LAST_IDX) begin
              idx_q  <= '0;
              last_q <= 1'b0;
              if (repeat_en) begin
                pattern_q <= to_pattern('0);
              end else begin
                state_q   <= DONE;
                pattern_q <= '0;
                valid_q   <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              idx_q     <= idx_d;
              pattern_q <= to_pattern(idx_d);
              last_q    <= (idx_d == LAST_IDX);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pattern = pattern_q;
  assign valid   = valid_q;
  assign last    = last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_stim_seq.sv
// Self-checking bench for stim_seq: WIDTH=2/DWELL=50 and WIDTH=3/DWELL=1 instances
// driven from a vector table, with expected outputs passed through a scoreboard queue.
module tb_stim_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0, repeat_en = 1'b0;
  logic [1:0] pat_a;
  logic       va, la, ba, da;
  logic [2:0] pat_b;
  logic       vb, lb, bb, db;

  stim_seq #(.WIDTH(2), .DWELL(50)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .repeat_en(repeat_en), .pattern(pat_a), .valid(va), .last(la),
    .busy(ba), .done(da)
  );

  stim_seq #(.WIDTH(3), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .repeat_en(repeat_en), .pattern(pat_b), .valid(vb), .last(lb),
    .busy(bb), .done(db)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    bit          dut;
    logic        st, sp, hd, rp;
    int unsigned n;
    logic [2:0]  idx;
    logic        v, l, b, d;
    string       tag;
  } vec_t;

  typedef struct {
    bit         dut;
    logic [6:0] exp;
    string      tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [2:0] exp_pat(input logic [2:0] idx);
`ifdef STIM_SEQ_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  function automatic void add(input bit rb, input bit dut, input logic st, input logic sp,
                              input logic hd, input logic rp, input int unsigned n,
                              input logic [2:0] idx, input logic v, input logic l,
                              input logic b, input logic d, input string tag);
    vec_t r;
    r.rst_before = rb; r.dut = dut; r.st = st; r.sp = sp; r.hd = hd; r.rp = rp;
    r.n = n; r.idx = idx; r.v = v; r.l = l; r.b = b; r.d = d; r.tag = tag;
    vecs.push_back(r);
  endfunction

  function automatic logic [6:0] actual(input bit dut);
    return dut ? {pat_b, vb, lb, bb, db} : {1'b0, pat_a, va, la, ba, da};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {pat,v,l,b,d}=%b required=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_check();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; repeat_en = 1'b0;
    #1;
    check("reset_a", actual(1'b0), 7'b0);
    check("reset_b", actual(1'b1), 7'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t r);
    sb_t e;
    for (int unsigned c = 0; c < r.n; c++) begin
      @(negedge clk);
      start = r.st; stop = r.sp; hold = r.hd; repeat_en = r.rp;
      e.dut = r.dut;
      e.tag = r.tag;
      e.exp = {(r.v ? exp_pat(r.idx) : 3'b000), r.v, r.l, r.b, r.d};
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check(e.tag, actual(e.dut), e.exp);
    end
  endtask

  initial begin
    // Phase A1: full single sweep, start ignored in RUN and DONE.
    add(1, 0, 1, 0, 0, 0, 1,  0, 1, 0, 1, 0, "a1_start");
    add(0, 0, 0, 0, 0, 0, 49, 0, 1, 0, 1, 0, "a1_p0");
    add(0, 0, 1, 0, 0, 0, 50, 1, 1, 0, 1, 0, "a1_p1");
    add(0, 0, 0, 0, 0, 0, 50, 2, 1, 0, 1, 0, "a1_p2");
    add(0, 0, 0, 0, 0, 0, 50, 3, 1, 1, 1, 0, "a1_p3_last");
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, "a1_done");
    add(0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, "a1_start_in_done");
    add(0, 0, 0, 0, 0, 0, 2,  0, 0, 0, 0, 0, "a1_idle");
    // Phase A2: repeat wraps to index 0 without done, then stop.
    add(1, 0, 1, 0, 0, 1, 1,  0, 1, 0, 1, 0, "a2_start");
    add(0, 0, 0, 0, 0, 1, 49, 0, 1, 0, 1, 0, "a2_p0");
    add(0, 0, 0, 0, 0, 1, 50, 1, 1, 0, 1, 0, "a2_p1");
    add(0, 0, 0, 0, 0, 1, 50, 2, 1, 0, 1, 0, "a2_p2");
    add(0, 0, 0, 0, 0, 1, 50, 3, 1, 1, 1, 0, "a2_p3_last");
    add(0, 0, 0, 0, 0, 1, 50, 0, 1, 0, 1, 0, "a2_wrap_p0");
    add(0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 0, "a2_stop");
    // Phase A3: 10-cycle hold stretches pattern 1, stop, IDLE corner cases.
    add(1, 0, 1, 0, 0, 0, 1,  0, 1, 0, 1, 0, "a3_start");
    add(0, 0, 0, 0, 0, 0, 49, 0, 1, 0, 1, 0, "a3_p0");
    add(0, 0, 0, 0, 0, 0, 10, 1, 1, 0, 1, 0, "a3_p1_pre");
    add(0, 0, 0, 0, 1, 0, 10, 1, 1, 0, 1, 0, "a3_p1_hold");
    add(0, 0, 0, 0, 0, 0, 40, 1, 1, 0, 1, 0, "a3_p1_post");
    add(0, 0, 0, 0, 0, 0, 10, 2, 1, 0, 1, 0, "a3_p2");
    add(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, "a3_stop");
    add(0, 0, 1, 1, 0, 0, 2,  0, 0, 0, 0, 0, "a3_start_stop_idle");
    add(0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, "a3_hold_idle");
    add(0, 0, 1, 0, 1, 0, 1,  0, 1, 0, 1, 0, "a3_start_with_hold");
    add(0, 0, 0, 0, 1, 0, 5,  0, 1, 0, 1, 0, "a3_held_p0");
    add(0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, "a3_stop_with_hold");
    // Phase B1: WIDTH=3, DWELL=1 sweep on consecutive cycles.
    add(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, "b1_p0");
    for (int unsigned i = 1; i < 8; i++)
      add(0, 1, 0, 0, 0, 0, 1, 3'(i), 1, (i == 7), 1, 0, "b1_pn");
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "b1_done");
    add(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, "b1_idle");
    // Phase B2: DWELL=1 with repeat.
    add(1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, "b2_p0");
    for (int unsigned i = 1; i < 8; i++)
      add(0, 1, 0, 0, 0, 1, 1, 3'(i), 1, (i == 7), 1, 0, "b2_pn");
    add(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, "b2_wrap_p0");
    add(0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, "b2_wrap_p1");
    add(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, "b2_stop");

    repeat (2) @(negedge clk);
    foreach (vecs[k]) begin
      if (vecs[k].rst_before) reset_check();
      run_vec(vecs[k]);
    end

    // Asynchronous reset mid-pattern, then a fresh sweep must restart at index 0.
    vecs.delete();
    add(0, 0, 1, 0, 0, 0, 1,  0, 1, 0, 1, 0, "r_start");
    add(0, 0, 0, 0, 0, 0, 49, 0, 1, 0, 1, 0, "r_p0");
    add(0, 0, 0, 0, 0, 0, 20, 1, 1, 0, 1, 0, "r_p1");
    add(0, 0, 1, 0, 0, 0, 1,  0, 1, 0, 1, 0, "r_restart");
    add(0, 0, 0, 0, 0, 0, 49, 0, 1, 0, 1, 0, "r_restart_p0");
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0, "r_restart_p1");
    reset_check();
    run_vec(vecs[0]);
    run_vec(vecs[1]);
    run_vec(vecs[2]);
    #3;
    rst = 1'b1;
    start = 1'b0;
    #1;
    check("async_rst_a", actual(1'b0), 7'b0);
    check("async_rst_b", actual(1'b1), 7'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[3]);
    run_vec(vecs[4]);
    run_vec(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
